parallel_out_bank: RTL and testbench

Memory-mapped multi-channel parallel output port on the processor's data bus. Decodes bus writes (`EN` + `Address`) to `NUM_CH` independent output channels plus one control register. Each channel is either a plain latched output with a one-cycle strobe, or a strobe/acknowledge handshake output with a one-entry pending buffer and a sticky overflow flag. Sits beside data RAM on the same write bus and drives external peripherals (LEDs, displays, handshaking devices).

---
 rtl/parallel_out_pkg.sv | 16 +
 rtl/parallel_out_chan.sv | 116 +++++++++++
 rtl/parallel_out_bank.sv | 80 ++++++++
 tb/tb_parallel_out_bank.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/parallel_out_pkg.sv
// Shared types and constants for the memory-mapped parallel output bank.
package parallel_out_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } chan_state_t;

  localparam logic [7:0] DEF_BASE_ADDR = 8'hFC;
  localparam logic [7:0] DEF_CTRL_ADDR = 8'hFB;

  localparam logic MODE_LATCH  = 1'b0;
  localparam logic MODE_HSHAKE = 1'b1;

endpackage

// File: rtl/parallel_out_chan.sv
// One output channel: latch mode with a one-cycle strobe, or a strobe/ack
// handshake with a one-entry pending buffer and a sticky overflow flag.
module parallel_out_chan
  import parallel_out_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode_i,
  input  logic              wr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              ack_i,
  input  logic              clr_ovf_i,
  output logic [DATA_W-1:0] data_o,
  output logic              strobe_o,
  output logic              ovf_o,
  output chan_state_t       state_o
);

  chan_state_t       state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] pend_q, pend_d;
  logic              pend_vld_q, pend_vld_d;
  logic              ovf_q, ovf_d;
  logic              strobe_q, strobe_d;
  logic              hshake;
  logic              drain;

  // A busy channel keeps handshaking until idle; only then does a new mode apply.
  assign hshake = (state_q != IDLE) || (mode_i == MODE_HSHAKE);
  assign drain  = (state_q == SEND) && ack_i;

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    ovf_d      = ovf_q;
    strobe_d   = 1'b0;

    if (!hshake) begin
      if (wr_i) begin
        data_d   = wr_data_i;
        strobe_d = 1'b1;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (wr_i) begin
            data_d  = wr_data_i;
            state_d = SEND;
          end
        end
        SEND, GAP: begin
          if (state_q == GAP) begin
            state_d = SEND;
          end else if (drain) begin
            state_d = (pend_vld_q || wr_i) ? GAP : IDLE;
          end

          if (drain) begin
            // Pending drains to the output; a same-edge write refills pending.
            if (pend_vld_q) begin
              data_d = pend_q;
              if (wr_i) begin
                pend_d = wr_data_i;
              end else begin
                pend_vld_d = 1'b0;
              end
            end else if (wr_i) begin
              data_d = wr_data_i;
            end
          end else if (wr_i) begin
            if (pend_vld_q) begin
              ovf_d = 1'b1;
            end else begin
              pend_d     = wr_data_i;
              pend_vld_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
      strobe_d = (state_d == SEND);
    end

    if (clr_ovf_i) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      data_q     <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      ovf_q      <= 1'b0;
      strobe_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      ovf_q      <= ovf_d;
      strobe_q   <= strobe_d;
    end
  end

  assign data_o   = data_q;
  assign strobe_o = strobe_q;
  assign ovf_o    = ovf_q;
  assign state_o  = state_q;

endmodule

// File: rtl/parallel_out_bank.sv
// Bus-write decode, mode/control register and output packing for NUM_CH
// independent parallel output channels.
module parallel_out_bank
  import parallel_out_pkg::*;
#(
  parameter int              DATA_W    = 8,
  parameter int              ADDR_W    = 8,
  parameter int              NUM_CH    = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter logic [ADDR_W-1:0] CTRL_ADDR = DEF_CTRL_ADDR
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     EN,
  input  logic [ADDR_W-1:0]        Address,
  input  logic [DATA_W-1:0]        RegData,
  input  logic [NUM_CH-1:0]        Ack,
  output logic [NUM_CH*DATA_W-1:0] DataOut,
  output logic [NUM_CH-1:0]        Strobe,
  output logic [NUM_CH-1:0]        Busy,
  output logic [NUM_CH-1:0]        Overflow
);

  localparam longint BASE_I = longint'(BASE_ADDR);
  localparam longint CTRL_I = longint'(CTRL_ADDR);
  localparam longint SPACE  = longint'(1) << ADDR_W;

  if (NUM_CH < 1 || NUM_CH > DATA_W) begin : g_bad_num_ch
    $error("parallel_out_bank: NUM_CH must be in 1..DATA_W");
  end
  if (BASE_I + NUM_CH > SPACE) begin : g_bad_base
    $error("parallel_out_bank: channel range exceeds address space");
  end
  if (CTRL_I >= BASE_I && CTRL_I < BASE_I + NUM_CH) begin : g_bad_ctrl
    $error("parallel_out_bank: CTRL_ADDR overlaps channel range");
  end

  logic [NUM_CH-1:0] mode_q;
  logic              ctrl_wr;
  logic [NUM_CH-1:0] chan_wr;
  chan_state_t       chan_state [NUM_CH];

  assign ctrl_wr = EN && (Address == CTRL_ADDR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q <= '0;
    end else if (ctrl_wr) begin
      mode_q <= RegData[NUM_CH-1:0];
    end
  end

  if (NUM_CH < DATA_W) begin : g_unused_data
    logic unused_regdata;
    assign unused_regdata = ^RegData[DATA_W-1:NUM_CH];
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    assign chan_wr[i] = EN && (Address == ADDR_W'(BASE_I + i));

    parallel_out_chan #(
      .DATA_W (DATA_W)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst),
      .mode_i    (mode_q[i]),
      .wr_i      (chan_wr[i]),
      .wr_data_i (RegData),
      .ack_i     (Ack[i]),
      .clr_ovf_i (ctrl_wr),
      .data_o    (DataOut[i*DATA_W +: DATA_W]),
      .strobe_o  (Strobe[i]),
      .ovf_o     (Overflow[i]),
      .state_o   (chan_state[i])
    );

    assign Busy[i] = (chan_state[i] != IDLE);
  end

endmodule

// File: tb/tb_parallel_out_bank.sv
// Directed bench for parallel_out_bank: latch mode, handshake queueing,
// overflow, ack/write collision, mode switch and asynchronous reset.
module tb_parallel_out_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic        EN;
  logic [7:0]  Address;
  logic [7:0]  RegData;
  logic [3:0]  Ack;
  logic [31:0] DataOut;
  logic [3:0]  Strobe;
  logic [3:0]  Busy;
  logic [3:0]  Overflow;

  int vec_cnt = 0;
  int err_cnt = 0;

  parallel_out_bank dut (
    .clk      (clk),
    .rst      (rst),
    .EN       (EN),
    .Address  (Address),
    .RegData  (RegData),
    .Ack      (Ack),
    .DataOut  (DataOut),
    .Strobe   (Strobe),
    .Busy     (Busy),
    .Overflow (Overflow)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drives one bus write for the next rising edge; returns at the following negedge.
  task automatic bus_wr(input logic [7:0] a, input logic [7:0] d);
    EN      = 1'b1;
    Address = a;
    RegData = d;
    @(negedge clk);
    EN      = 1'b0;
    Address = 8'h00;
    RegData = 8'h00;
  endtask

  task automatic pulse_ack(input logic [3:0] m);
    Ack = m;
    @(negedge clk);
    Ack = 4'h0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; EN = 1'b0; Address = 8'h00; RegData = 8'h00; Ack = 4'h0;
    repeat (2) @(negedge clk);
    check_vec("rst_data", DataOut, 32'h0);
    check_vec("rst_strobe", {28'h0, Strobe}, 32'h0);
    check_vec("rst_busy", {28'h0, Busy}, 32'h0);
    check_vec("rst_ovf", {28'h0, Overflow}, 32'h0);
    rst = 1'b1;
    step();

    // Latch mode
    bus_wr(8'hFC, 8'hA5);
    check_vec("latch_data", DataOut, 32'h0000_00A5);
    check_vec("latch_strobe_hi", {28'h0, Strobe}, 32'h1);
    check_vec("latch_busy", {28'h0, Busy}, 32'h0);
    step();
    check_vec("latch_strobe_lo", {28'h0, Strobe}, 32'h0);
    bus_wr(8'hFA, 8'h5A);
    check_vec("unmapped_data", DataOut, 32'h0000_00A5);
    check_vec("unmapped_strobe", {28'h0, Strobe}, 32'h0);
    Ack = 4'h8;
    bus_wr(8'hFF, 8'h3C);
    Ack = 4'h0;
    check_vec("latch_ch3_data", DataOut, 32'h3C00_00A5);
    check_vec("latch_ch3_strobe", {28'h0, Strobe}, 32'h8);
    check_vec("latch_ch3_busy", {28'h0, Busy}, 32'h0);

    // Handshake: stall without ack
    bus_wr(8'hFB, 8'h01);
    check_vec("ctrl_strobe", {28'h0, Strobe}, 32'h0);
    bus_wr(8'hFC, 8'h11);
    check_vec("hs_data", DataOut, 32'h3C00_0011);
    check_vec("hs_strobe", {28'h0, Strobe}, 32'h1);
    check_vec("hs_busy", {28'h0, Busy}, 32'h1);
    for (int i = 0; i < 4; i++) begin
      step();
      check_vec("hs_hold_strobe", {28'h0, Strobe}, 32'h1);
      check_vec("hs_hold_data", {24'h0, DataOut[7:0]}, 32'h11);
    end
    pulse_ack(4'h1);
    check_vec("hs_ack_strobe", {28'h0, Strobe}, 32'h0);
    check_vec("hs_ack_busy", {28'h0, Busy}, 32'h0);

    // Pending + overflow
    bus_wr(8'hFC, 8'h11);
    bus_wr(8'hFC, 8'h22);
    bus_wr(8'hFC, 8'h33);
    check_vec("ovf_set", {28'h0, Overflow}, 32'h1);
    check_vec("ovf_data", {24'h0, DataOut[7:0]}, 32'h11);
    check_vec("ovf_strobe", {28'h0, Strobe}, 32'h1);
    pulse_ack(4'h1);
    check_vec("gap_strobe", {28'h0, Strobe}, 32'h0);
    check_vec("gap_busy", {28'h0, Busy}, 32'h1);
    check_vec("gap_data", {24'h0, DataOut[7:0]}, 32'h22);
    step();
    check_vec("send2_strobe", {28'h0, Strobe}, 32'h1);
    check_vec("send2_data", {24'h0, DataOut[7:0]}, 32'h22);
    pulse_ack(4'h1);
    check_vec("drop_idle", {28'h0, Busy}, 32'h0);
    check_vec("ovf_sticky", {28'h0, Overflow}, 32'h1);
    bus_wr(8'hFB, 8'h01);
    check_vec("ovf_clear", {28'h0, Overflow}, 32'h0);

    // Ack and write on the same edge with pending full
    bus_wr(8'hFC, 8'h11);
    bus_wr(8'hFC, 8'h22);
    Ack = 4'h1;
    bus_wr(8'hFC, 8'h44);
    Ack = 4'h0;
    check_vec("coll_data", {24'h0, DataOut[7:0]}, 32'h22);
    check_vec("coll_strobe", {28'h0, Strobe}, 32'h0);
    check_vec("coll_ovf", {28'h0, Overflow}, 32'h0);
    step();
    check_vec("coll_send", {28'h0, Strobe}, 32'h1);
    pulse_ack(4'h1);
    check_vec("coll_next_data", {24'h0, DataOut[7:0]}, 32'h44);
    check_vec("coll_next_strobe", {28'h0, Strobe}, 32'h0);
    step();
    check_vec("coll_next_send", {28'h0, Strobe}, 32'h1);
    pulse_ack(4'h1);
    check_vec("coll_idle", {28'h0, Busy}, 32'h0);

    // Ack held high: 1,0,1,0 strobe pattern
    Ack = 4'h1;
    bus_wr(8'hFC, 8'hAA);
    check_vec("bb_s0", {28'h0, Strobe}, 32'h1);
    check_vec("bb_d0", {24'h0, DataOut[7:0]}, 32'hAA);
    bus_wr(8'hFC, 8'hBB);
    check_vec("bb_s1", {28'h0, Strobe}, 32'h0);
    check_vec("bb_d1", {24'h0, DataOut[7:0]}, 32'hBB);
    step();
    check_vec("bb_s2", {28'h0, Strobe}, 32'h1);
    check_vec("bb_d2", {24'h0, DataOut[7:0]}, 32'hBB);
    step();
    check_vec("bb_s3", {28'h0, Strobe}, 32'h0);
    check_vec("bb_busy3", {28'h0, Busy}, 32'h0);
    Ack = 4'h0;

    // Mode switch to latch while ch0 is in SEND
    bus_wr(8'hFC, 8'h66);
    bus_wr(8'hFB, 8'h00);
    check_vec("msw_busy", {28'h0, Busy}, 32'h1);
    check_vec("msw_strobe", {28'h0, Strobe}, 32'h1);
    step();
    check_vec("msw_hold", {28'h0, Strobe}, 32'h1);
    pulse_ack(4'h1);
    check_vec("msw_done_strobe", {28'h0, Strobe}, 32'h0);
    check_vec("msw_done_busy", {28'h0, Busy}, 32'h0);
    bus_wr(8'hFC, 8'h77);
    check_vec("msw_latch_data", {24'h0, DataOut[7:0]}, 32'h77);
    check_vec("msw_latch_strobe", {28'h0, Strobe}, 32'h1);
    check_vec("msw_latch_busy", {28'h0, Busy}, 32'h0);
    step();
    check_vec("msw_latch_lo", {28'h0, Strobe}, 32'h0);

    // Handshake on ch3, then asynchronous reset mid-SEND
    bus_wr(8'hFB, 8'h08);
    bus_wr(8'hFF, 8'hC3);
    check_vec("ch3_hs_data", DataOut, 32'hC300_0077);
    check_vec("ch3_hs_strobe", {28'h0, Strobe}, 32'h8);
    check_vec("ch3_hs_busy", {28'h0, Busy}, 32'h8);
    #2 rst = 1'b0;
    #1;
    check_vec("arst_data", DataOut, 32'h0);
    check_vec("arst_strobe", {28'h0, Strobe}, 32'h0);
    check_vec("arst_busy", {28'h0, Busy}, 32'h0);
    check_vec("arst_ovf", {28'h0, Overflow}, 32'h0);
    step();
    rst = 1'b1;
    step();
    bus_wr(8'hFF, 8'h12);
    check_vec("post_rst_data", DataOut, 32'h1200_0000);
    check_vec("post_rst_strobe", {28'h0, Strobe}, 32'h8);
    check_vec("post_rst_busy", {28'h0, Busy}, 32'h0);
    step();
    check_vec("post_rst_lo", {28'h0, Strobe}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
